// File: rtl/s32x_sdr_bridge_if.sv
// s32x_sdr_bridge_if: the signals that cross the bridge.
//   32X side : SDR_A, SDR_DO, SDR_CS, SDR_WE, SDR_RD  -> bridge
//              SDR_DI, SDR_WAIT                       <- bridge
//   Mem side : MEM_ADDR, MEM_DO, MEM_BE, MEM_WR, MEM_REQ <- bridge
//              MEM_ACK, MEM_DI                           -> bridge
//   Status   : ERR (sticky watchdog flag)                <- bridge
// The slave modport is the bridge. The master modport is whoever drives
// the 32X strobes and models the memory controller.
interface s32x_sdr_bridge_if;
  logic [16:0] SDR_A;
  logic [15:0] SDR_DO;
  logic        SDR_CS;
  logic [1:0]  SDR_WE;
  logic        SDR_RD;
  logic [15:0] SDR_DI;
  logic        SDR_WAIT;
  logic [16:0] MEM_ADDR;
  logic [15:0] MEM_DO;
  logic [1:0]  MEM_BE;
  logic        MEM_WR;
  logic        MEM_REQ;
  logic        MEM_ACK;
  logic [15:0] MEM_DI;
  logic        ERR;

  modport slave (
    input  SDR_A, SDR_DO, SDR_CS, SDR_WE, SDR_RD, MEM_ACK, MEM_DI,
    output SDR_DI, SDR_WAIT, MEM_ADDR, MEM_DO, MEM_BE, MEM_WR, MEM_REQ, ERR
  );

  modport master (
    output SDR_A, SDR_DO, SDR_CS, SDR_WE, SDR_RD, MEM_ACK, MEM_DI,
    input  SDR_DI, SDR_WAIT, MEM_ADDR, MEM_DO, MEM_BE, MEM_WR, MEM_REQ, ERR
  );
endinterface

// File: rtl/s32x_sdr_bridge.sv
// s32x_sdr_bridge: turns the level-style 32X SH-2 SDRAM access into one
// req/ack transaction on the board memory controller, holds read data for
// the 32X and runs a watchdog so a dead controller cannot hang the SH-2s.
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : s32x_sdr_bridge_if.slave (32X strobes, controller req/ack, ERR)
// Parameters:
//   TIMEOUT  : BUSY cycles before forced completion (0 = no watchdog)
//   CNT_W    : watchdog counter width, 2**CNT_W > TIMEOUT
// Build option:
//   S32X_SDR_WPOST_EN : posted writes; a write never raises SDR_WAIT and
//                       retires in the background through the POST state.
module s32x_sdr_bridge #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input logic              CLK,
  input logic              RST,
  s32x_sdr_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
`ifdef S32X_SDR_WPOST_EN
    DONE,
    POST
`else
    DONE
`endif
  } st_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  st_t         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [16:0] addr_q;
  logic [15:0] do_q, di_q;
  logic [1:0]  be_q;
  logic        wr_q, req_q, wait_q, err_q;

  logic is_wr, active, differ, wd_hit;

  assign is_wr  = |bus.SDR_WE;
  assign active = bus.SDR_CS & (bus.SDR_RD | is_wr);
  // A held access matching the one just served is the same access, not a new one.
  assign differ = (bus.SDR_A != addr_q) || (is_wr != wr_q);
  assign wd_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      do_q    <= '0;
      di_q    <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      wait_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (active) begin
            addr_q <= bus.SDR_A;
            do_q   <= bus.SDR_DO;
            wr_q   <= is_wr;
            be_q   <= is_wr ? bus.SDR_WE : 2'b11;
            req_q  <= 1'b1;
            cnt_q  <= '0;
`ifdef S32X_SDR_WPOST_EN
            wait_q  <= ~is_wr;
            state_q <= is_wr ? POST : BUSY;
`else
            wait_q  <= 1'b1;
            state_q <= BUSY;
`endif
          end else begin
            wait_q <= 1'b0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // Ack has priority over the watchdog in the same cycle.
          if (bus.MEM_ACK) begin
            req_q   <= 1'b0;
            wait_q  <= 1'b0;
            state_q <= DONE;
            if (!wr_q) di_q <= bus.MEM_DI;
          end else if (wd_hit) begin
            req_q   <= 1'b0;
            wait_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DONE;
            if (!wr_q) di_q <= 16'hFFFF;
          end
        end
`ifdef S32X_SDR_WPOST_EN
        POST: begin
          cnt_q  <= cnt_q + 1'b1;
          // A different access behind the posted write stalls the 32X; the
          // stall is carried through DONE/IDLE until that access is issued.
          wait_q <= active & differ;
          if (bus.MEM_ACK || wd_hit) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!bus.MEM_ACK) err_q <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (!active) wait_q <= 1'b0;
          if (!active || differ) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.SDR_DI   = di_q;
  assign bus.SDR_WAIT = wait_q;
  assign bus.MEM_ADDR = addr_q;
  assign bus.MEM_DO   = do_q;
  assign bus.MEM_BE   = be_q;
  assign bus.MEM_WR   = wr_q;
  assign bus.MEM_REQ  = req_q;
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_s32x_sdr_bridge.sv
// Directed bench for s32x_sdr_bridge (TIMEOUT=8). Inputs are driven and
// outputs sampled on the falling edge; the design acts on the rising edge.
module tb_s32x_sdr_bridge;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   req_rises = 0;
  logic req_prev  = 1'b0;

  s32x_sdr_bridge_if bus ();

  s32x_sdr_bridge #(.TIMEOUT(8), .CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Counts MEM_REQ assertions shortly after each rising edge.
  always @(posedge CLK) begin
    #2;
    if (bus.MEM_REQ && !req_prev) req_rises++;
    req_prev = bus.MEM_REQ;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    bus.SDR_A = '0; bus.SDR_DO = '0; bus.SDR_CS = 1'b0; bus.SDR_WE = 2'b00;
    bus.SDR_RD = 1'b0; bus.MEM_ACK = 1'b0; bus.MEM_DI = '0;
    cyc(2);
    chk("rst_req",  32'(bus.MEM_REQ),  0);
    chk("rst_wait", 32'(bus.SDR_WAIT), 0);
    chk("rst_di",   32'(bus.SDR_DI),   0);
    chk("rst_err",  32'(bus.ERR),      0);
    RST = 1'b0;
    cyc(1);

    // Read at 0x00100, ack 3 cycles after request with BEEF.
    bus.SDR_A = 17'h00100; bus.SDR_CS = 1'b1; bus.SDR_RD = 1'b1;
    cyc(1);
    chk("rd_wait_up", 32'(bus.SDR_WAIT), 1);
    chk("rd_req",     32'(bus.MEM_REQ),  1);
    chk("rd_addr",    32'(bus.MEM_ADDR), 32'h00100);
    chk("rd_be",      32'(bus.MEM_BE),   3);
    chk("rd_wr",      32'(bus.MEM_WR),   0);
    cyc(2);
    chk("rd_wait_hold", 32'(bus.SDR_WAIT), 1);
    bus.MEM_ACK = 1'b1; bus.MEM_DI = 16'hBEEF;
    cyc(1);
    bus.MEM_ACK = 1'b0; bus.MEM_DI = 16'h0000;
    chk("rd_wait_dn", 32'(bus.SDR_WAIT), 0);
    chk("rd_req_dn",  32'(bus.MEM_REQ),  0);
    chk("rd_di",      32'(bus.SDR_DI),   32'hBEEF);

    // Held 10 cycles: no re-issue.
    cyc(10);
    chk("hold_req",   32'(bus.MEM_REQ), 0);
    chk("hold_rises", req_rises,        1);

    // Address change while held: new request 2 cycles later.
    bus.SDR_A = 17'h00102;
    cyc(1);
    chk("chg_req0", 32'(bus.MEM_REQ), 0);
    cyc(1);
    chk("chg_req1",   32'(bus.MEM_REQ),  1);
    chk("chg_addr",   32'(bus.MEM_ADDR), 32'h00102);
    chk("chg_rises",  req_rises,         2);
    bus.MEM_ACK = 1'b1; bus.MEM_DI = 16'h5A5A;
    cyc(1);
    bus.MEM_ACK = 1'b0; bus.SDR_CS = 1'b0; bus.SDR_RD = 1'b0;
    chk("chg_di", 32'(bus.SDR_DI), 32'h5A5A);
    cyc(2);

    // Upper-byte write (RD also set: write wins).
    bus.SDR_A = 17'h1FFFF; bus.SDR_DO = 16'h1234; bus.SDR_WE = 2'b10;
    bus.SDR_RD = 1'b1; bus.SDR_CS = 1'b1;
    cyc(1);
    chk("wr_be",   32'(bus.MEM_BE),   2);
    chk("wr_wr",   32'(bus.MEM_WR),   1);
    chk("wr_addr", 32'(bus.MEM_ADDR), 32'h1FFFF);
    chk("wr_do",   32'(bus.MEM_DO),   32'h1234);
    chk("wr_req",  32'(bus.MEM_REQ),  1);
`ifdef S32X_SDR_WPOST_EN
    chk("wr_wait", 32'(bus.SDR_WAIT), 0);
`else
    chk("wr_wait", 32'(bus.SDR_WAIT), 1);
`endif
    bus.MEM_ACK = 1'b1; bus.MEM_DI = 16'h7777;
    cyc(1);
    bus.MEM_ACK = 1'b0;
    chk("wr_di_kept", 32'(bus.SDR_DI),   32'h5A5A);
    chk("wr_req_dn",  32'(bus.MEM_REQ),  0);
    chk("wr_wait_dn", 32'(bus.SDR_WAIT), 0);
    bus.SDR_CS = 1'b0; bus.SDR_RD = 1'b0; bus.SDR_WE = 2'b00;
    cyc(2);

    // Watchdog: no ack, completes after 8 BUSY cycles.
    bus.SDR_A = 17'h00200; bus.SDR_CS = 1'b1; bus.SDR_RD = 1'b1;
    cyc(1);
    chk("to_wait0", 32'(bus.SDR_WAIT), 1);
    cyc(7);
    chk("to_wait7", 32'(bus.SDR_WAIT), 1);
    chk("to_err7",  32'(bus.ERR),      0);
    cyc(1);
    chk("to_wait8", 32'(bus.SDR_WAIT), 0);
    chk("to_req8",  32'(bus.MEM_REQ),  0);
    chk("to_di",    32'(bus.SDR_DI),   32'hFFFF);
    chk("to_err",   32'(bus.ERR),      1);
    bus.MEM_ACK = 1'b1; bus.MEM_DI = 16'h1111;
    cyc(1);
    bus.MEM_ACK = 1'b0;
    chk("late_ack_di",  32'(bus.SDR_DI),  32'hFFFF);
    chk("late_ack_req", 32'(bus.MEM_REQ), 0);
    bus.SDR_CS = 1'b0; bus.SDR_RD = 1'b0;
    cyc(3);
    chk("err_sticky", 32'(bus.ERR), 1);

    // Reset mid-BUSY.
    bus.SDR_A = 17'h00300; bus.SDR_CS = 1'b1; bus.SDR_RD = 1'b1;
    cyc(1);
    chk("pre_rst_req", 32'(bus.MEM_REQ), 1);
    RST = 1'b1;
    #1;
    chk("arst_req",  32'(bus.MEM_REQ),  0);
    chk("arst_wait", 32'(bus.SDR_WAIT), 0);
    chk("arst_di",   32'(bus.SDR_DI),   0);
    chk("arst_err",  32'(bus.ERR),      0);
    cyc(1);
    RST = 1'b0;
    cyc(1);
    chk("post_rst_req",  32'(bus.MEM_REQ),  1);
    chk("post_rst_addr", 32'(bus.MEM_ADDR), 32'h00300);

    // Ack on the last watchdog cycle: ack wins, no ERR.
    cyc(7);
    bus.MEM_ACK = 1'b1; bus.MEM_DI = 16'hCAFE;
    cyc(1);
    bus.MEM_ACK = 1'b0;
    chk("tie_di",   32'(bus.SDR_DI),   32'hCAFE);
    chk("tie_err",  32'(bus.ERR),      0);
    chk("tie_wait", 32'(bus.SDR_WAIT), 0);
    bus.SDR_CS = 1'b0; bus.SDR_RD = 1'b0;
    cyc(2);

`ifdef S32X_SDR_WPOST_EN
    // Posted write then a read elsewhere; write ack 5 cycles after request.
    bus.SDR_A = 17'h00010; bus.SDR_DO = 16'hAAAA; bus.SDR_WE = 2'b11; bus.SDR_CS = 1'b1;
    cyc(1);
    chk("pw_wait", 32'(bus.SDR_WAIT), 0);
    chk("pw_req",  32'(bus.MEM_REQ),  1);
    chk("pw_wr",   32'(bus.MEM_WR),   1);
    bus.SDR_WE = 2'b00; bus.SDR_RD = 1'b1; bus.SDR_A = 17'h00020;
    cyc(4);
    chk("pw_rd_wait", 32'(bus.SDR_WAIT), 1);
    chk("pw_addr",    32'(bus.MEM_ADDR), 32'h00010);
    bus.MEM_ACK = 1'b1;
    cyc(1);
    bus.MEM_ACK = 1'b0;
    chk("pw_ret_req",  32'(bus.MEM_REQ),  0);
    chk("pw_ret_wait", 32'(bus.SDR_WAIT), 1);
    cyc(2);
    chk("pw_rd_req",  32'(bus.MEM_REQ),  1);
    chk("pw_rd_addr", 32'(bus.MEM_ADDR), 32'h00020);
    chk("pw_rd_wr",   32'(bus.MEM_WR),   0);
    chk("pw_rd_wt",   32'(bus.SDR_WAIT), 1);
    bus.MEM_ACK = 1'b1; bus.MEM_DI = 16'h4321;
    cyc(1);
    bus.MEM_ACK = 1'b0;
    chk("pw_rd_di", 32'(bus.SDR_DI), 32'h4321);
    bus.SDR_CS = 1'b0; bus.SDR_RD = 1'b0;
    cyc(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
